hdr_parser: RTL and testbench
=============================

Name: hdr_parser

Overview:
- Programmable header parser that sits directly upstream of the executor.
- Walks a captured packet header buffer using a reconfigurable parse graph, one header at a time.
- Produces the per-header byte offsets and the header buffer that the executor consumes.
- ready_o is a one-cycle pulse that drives the executor's start_i.

Parameters:
- HDR_MAX_LEN, 128: bytes in the header buffer.
- NUM_HEADERS, 16: header types and parse-table entries; header id width is 4 bits.
- MAX_TRANS, 4: transition entries per header type.
- ADDR_W, 8: byte-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start_i  in  1  begin parsing pkt_hdr_i; accepted only in FREE.
- pkt_hdr_i  in  8 x HDR_MAX_LEN  raw header bytes; index 0 is the first byte on the wire.
- ready_o  out  1  one-cycle pulse: parse finished, outputs valid.
- pkt_hdr_o  out  8 x HDR_MAX_LEN  copy of pkt_hdr_i latched at start.
- parsed_hdrs_o  out  32 x NUM_HEADERS  start byte offset of each header; 0 if not parsed.
- hdr_valid_o  out  NUM_HEADERS  bit h set when header h was parsed.
- err_o  out  1  parse aborted; qualified by ready_o.
- mod_start_i  in  1  load new parse configuration; accepted only in FREE.
- mod_hdr_cfg_i  in  16 x NUM_HEADERS  per-header config.
  - [15:8] hdr_len in bytes; 0 means not configured.
  - [7:2] key_off.
  - [1] key_wide.
  - [0] reserved.
- mod_trans_i  in  24 x (NUM_HEADERS*MAX_TRANS)  transition table; entry index is h*MAX_TRANS+t.
  - [23] valid.
  - [19:16] next header id.
  - [15:0] match value.

Behaviour:
- Reset (asynchronous, any state, including mid-parse):
  - state=FREE; ready_o=0, err_o=0, hdr_valid_o=0.
  - parsed_hdrs_o all 0, pkt_hdr_o all 0.
  - Both config tables cleared to 0.
  - Internal cursor and current header id cleared to 0.
- FREE:
  - mod_start_i=1: latch both config tables; stay in FREE.
  - Otherwise, start_i=1:
    - Latch pkt_hdr_i into pkt_hdr_o.
    - Clear hdr_valid_o, parsed_hdrs_o and err_o.
    - Set cursor=0 and cur_hdr=0; go to EXTRACT.
  - Both mod_start_i and start_i high: mod wins and start is dropped.
  - In any other state, start_i and mod_start_i are ignored (no queueing).
- EXTRACT (1 cycle). Let cfg=hdr_cfg[cur_hdr].
  - Error, go to DONE with err_o<=1 if any of:
    - cfg.hdr_len==0;
    - hdr_valid_o[cur_hdr] is already set (loop);
    - cursor+hdr_len > HDR_MAX_LEN;
    - the key bytes lie outside the buffer: cursor+key_off+(key_wide?2:1) > HDR_MAX_LEN.
  - Otherwise:
    - parsed_hdrs_o[cur_hdr]<=cursor; hdr_valid_o[cur_hdr]<=1.
    - Latch the key:
      - key_wide=1: key={byte[a], byte[a+1]}, big-endian, where a=cursor+key_off.
      - key_wide=0: key={8'h00, byte[a]}.
    - Advance cursor by hdr_len.
    - Go to LOOKUP.
  - All address arithmetic is done at ADDR_W+1 bits so that overflow is detectable.
- LOOKUP (1 cycle):
  - Compare the key against all MAX_TRANS entries of cur_hdr in parallel.
  - The lowest-index entry with valid=1 and a matching value wins: cur_hdr<=its next id; go to EXTRACT.
  - No match: normal termination; go to DONE with err_o=0.
- DONE (1 cycle): ready_o<=1, go to FREE. ready_o is cleared on the following cycle.
- Latency:
  - N headers parsed successfully: ready_o is high in the cycle 2N+1 edges after the start-accept edge.
  - Error detected in the EXTRACT of header k (1-based): ready_o is high 2k edges after the start-accept edge.
- Outputs after ready_o:
  - parsed_hdrs_o, hdr_valid_o, pkt_hdr_o and err_o hold until the next accepted start_i or reset.
  - On error, headers parsed before the error stay valid.
- The loop check bounds any parse to at most NUM_HEADERS headers.

Test Plan:
1. Eth/IPv4/UDP. Config:
   - hdr0 len 14, key_off 12, wide; trans 0x0800->1.
   - hdr1 len 20, key_off 9, narrow; trans 0x0011->2.
   - hdr2 len 8, no valid trans.
   - Packet bytes [12:13]=08 00, [23]=0x11.
   - Required: ready_o 7 cycles after start; parsed_hdrs 0/14/34; hdr_valid_o=0x0007; err_o=0; pkt_hdr_o equals input.
2. Same config, ethertype 0x86DD: required ready_o after 3 cycles; hdr_valid_o=0x0001; err_o=0.
3. Loop, then unconfigured header:
   - Loop: hdr1 trans 0x0011->0 with config as in 1. Required err_o=1 in the EXTRACT of the second hdr0 visit; hdr_valid_o=0x0003; ready_o after 6 cycles.
   - Then set hdr2 len=0 and rerun packet 1. Required err_o=1; hdr_valid_o=0x0003.
4. Bounds: hdr0 len 120, trans to hdr1 len 20. Required err_o=1; parsed_hdrs_o[1]=0; hdr_valid_o=0x0001.
5. Handshake arbitration:
   - start_i and mod_start_i in the same FREE cycle: config loads and no parse runs (ready_o stays 0).
   - start_i pulsed mid-parse: ignored; exactly one ready_o.
   - Priority: two valid entries that both match 0x0800 -> the lower index is taken.
6. rst asserted asynchronously mid-LOOKUP:
   - Required: outputs and tables zero immediately; FREE.
   - A following start with unconfigured tables gives err_o=1 and ready_o after 2 cycles.

Source files
------------

// File: rtl/hdr_parser.sv
// Programmable header parser. Walks the latched header buffer through a
// configurable parse graph (one EXTRACT + LOOKUP pair per header) and reports
// per-header offsets to the downstream executor with a one-cycle ready pulse.
module hdr_parser #(
  parameter int unsigned HDR_MAX_LEN = 128,
  parameter int unsigned NUM_HEADERS = 16,
  parameter int unsigned MAX_TRANS   = 4,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start_i,
  input  logic [HDR_MAX_LEN-1:0][7:0]            pkt_hdr_i,
  output logic                                   ready_o,
  output logic [HDR_MAX_LEN-1:0][7:0]            pkt_hdr_o,
  output logic [NUM_HEADERS-1:0][31:0]           parsed_hdrs_o,
  output logic [NUM_HEADERS-1:0]                 hdr_valid_o,
  output logic                                   err_o,
  input  logic                                   mod_start_i,
  input  logic [NUM_HEADERS-1:0][15:0]           mod_hdr_cfg_i,
  input  logic [NUM_HEADERS*MAX_TRANS-1:0][23:0] mod_trans_i
);

  localparam int unsigned HdrW = $clog2(NUM_HEADERS);
  localparam int unsigned IdxW = $clog2(HDR_MAX_LEN);
  localparam int unsigned Aw1  = ADDR_W + 1;
  // One extra address bit so cursor + length overflow is visible.
  localparam logic [ADDR_W:0] MaxLen = Aw1'(HDR_MAX_LEN);

  typedef enum logic [1:0] {StFree, StExtract, StLookup, StDone} state_e;

  state_e                                       state_q, state_d;
  logic [ADDR_W-1:0]                            cursor_q, cursor_d;
  logic [HdrW-1:0]                              cur_hdr_q, cur_hdr_d;
  logic [15:0]                                  key_q, key_d;
  logic                                         ready_q, ready_d;
  logic                                         err_q, err_d;
  logic [NUM_HEADERS-1:0]                       valid_q, valid_d;
  logic [NUM_HEADERS-1:0][31:0]                 parsed_q, parsed_d;
  logic [HDR_MAX_LEN-1:0][7:0]                  pkt_q, pkt_d;
  logic [NUM_HEADERS-1:0][15:0]                 cfg_q, cfg_d;
  // Same bit layout as mod_trans_i: entry [h][t] is flat entry h*MAX_TRANS+t.
  logic [NUM_HEADERS-1:0][MAX_TRANS-1:0][23:0]  trans_q, trans_d;

  logic [7:0]        hdr_len;
  logic [5:0]        key_off;
  logic              key_wide;
  logic [ADDR_W:0]   end_addr, key_a, key_end;
  logic [IdxW-1:0]   idx0, idx1;
  logic              extract_err;
  logic [15:0]       key_next;
  logic              match_found;
  logic [HdrW-1:0]   match_next;
  logic              unused_rsvd;

  // Decode the current header's config and compute bounds and key fetch.
  always_comb begin
    hdr_len     = cfg_q[cur_hdr_q][15:8];
    key_off     = cfg_q[cur_hdr_q][7:2];
    key_wide    = cfg_q[cur_hdr_q][1];
    end_addr    = Aw1'(cursor_q) + Aw1'(hdr_len);
    key_a       = Aw1'(cursor_q) + Aw1'(key_off);
    key_end     = key_a + (key_wide ? Aw1'(2) : Aw1'(1));
    extract_err = (hdr_len == 8'd0) || valid_q[cur_hdr_q] ||
                  (end_addr > MaxLen) || (key_end > MaxLen);
    idx0        = key_a[IdxW-1:0];
    idx1        = idx0 + IdxW'(1);
    key_next    = key_wide ? {pkt_q[idx0], pkt_q[idx1]} : {8'h00, pkt_q[idx0]};
  end

  // Parallel transition match; lowest matching index wins.
  always_comb begin
    match_found = 1'b0;
    match_next  = '0;
    for (int unsigned t = 0; t < MAX_TRANS; t++) begin
      if (!match_found && trans_q[cur_hdr_q][t][23] &&
          (trans_q[cur_hdr_q][t][15:0] == key_q)) begin
        match_found = 1'b1;
        match_next  = trans_q[cur_hdr_q][t][16 +: HdrW];
      end
    end
  end

  // Reserved config bits and unused next-id bits are stored but never decoded.
  always_comb begin
    unused_rsvd = 1'b0;
    for (int unsigned h = 0; h < NUM_HEADERS; h++) begin
      unused_rsvd ^= cfg_q[h][0];
      for (int unsigned t = 0; t < MAX_TRANS; t++) begin
        unused_rsvd ^= ^trans_q[h][t][22:16+HdrW];
      end
    end
  end

  // Next-state and datapath updates for the parse FSM.
  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    cur_hdr_d = cur_hdr_q;
    key_d     = key_q;
    ready_d   = 1'b0;
    err_d     = err_q;
    valid_d   = valid_q;
    parsed_d  = parsed_q;
    pkt_d     = pkt_q;
    cfg_d     = cfg_q;
    trans_d   = trans_q;
    unique case (state_q)
      StFree: begin
        if (mod_start_i) begin
          cfg_d   = mod_hdr_cfg_i;
          trans_d = mod_trans_i;
        end else if (start_i) begin
          pkt_d     = pkt_hdr_i;
          valid_d   = '0;
          parsed_d  = '0;
          err_d     = 1'b0;
          cursor_d  = '0;
          cur_hdr_d = '0;
          state_d   = StExtract;
        end
      end
      StExtract: begin
        if (extract_err) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          parsed_d[cur_hdr_q] = 32'(cursor_q);
          valid_d[cur_hdr_q]  = 1'b1;
          key_d               = key_next;
          cursor_d            = end_addr[ADDR_W-1:0];
          state_d             = StLookup;
        end
      end
      StLookup: begin
        if (match_found) begin
          cur_hdr_d = match_next;
          state_d   = StExtract;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        ready_d = 1'b1;
        state_d = StFree;
      end
      default: state_d = StFree;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFree;
      cursor_q  <= '0;
      cur_hdr_q <= '0;
      key_q     <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= '0;
      parsed_q  <= '0;
      pkt_q     <= '0;
      cfg_q     <= '0;
      trans_q   <= '0;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      cur_hdr_q <= cur_hdr_d;
      key_q     <= key_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      parsed_q  <= parsed_d;
      pkt_q     <= pkt_d;
      cfg_q     <= cfg_d;
      trans_q   <= trans_d;
    end
  end

  assign ready_o       = ready_q;
  assign err_o         = err_q;
  assign hdr_valid_o   = valid_q;
  assign parsed_hdrs_o = parsed_q;
  assign pkt_hdr_o     = pkt_q;

endmodule

// File: tb/tb_hdr_parser.sv
// Self-checking bench for hdr_parser: directed scenarios plus randomized parse
// graphs, all compared against a behavioural walk of the parse graph.
module tb_hdr_parser;

  logic                clk;
  logic                rst;
  logic                start_i;
  logic [127:0][7:0]   pkt_hdr_i;
  logic                ready_o;
  logic [127:0][7:0]   pkt_hdr_o;
  logic [15:0][31:0]   parsed_hdrs_o;
  logic [15:0]         hdr_valid_o;
  logic                err_o;
  logic                mod_start_i;
  logic [15:0][15:0]   mod_hdr_cfg_i;
  logic [63:0][23:0]   mod_trans_i;

  hdr_parser dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .pkt_hdr_i     (pkt_hdr_i),
    .ready_o       (ready_o),
    .pkt_hdr_o     (pkt_hdr_o),
    .parsed_hdrs_o (parsed_hdrs_o),
    .hdr_valid_o   (hdr_valid_o),
    .err_o         (err_o),
    .mod_start_i   (mod_start_i),
    .mod_hdr_cfg_i (mod_hdr_cfg_i),
    .mod_trans_i   (mod_trans_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side copy of the configuration and packet.
  logic [15:0] cfg   [16];
  logic [23:0] trans [16][4];
  logic [7:0]  pkt   [128];

  // Model results.
  logic [15:0][31:0] exp_parsed;
  logic [15:0]       exp_valid;
  logic              exp_err;
  int                exp_lat;
  int                last_lat;

  // Walk the parse graph with plain integer arithmetic.
  task automatic model();
    int cur, cursor, n, len, koff, wide, key, nxt, a;
    bit done, found;
    cur = 0; cursor = 0; n = 0; done = 0;
    exp_parsed = '0; exp_valid = '0; exp_err = 0; exp_lat = 0;
    while (!done) begin
      len  = int'(cfg[cur][15:8]);
      koff = int'(cfg[cur][7:2]);
      wide = int'(cfg[cur][1]);
      n++;
      if (len == 0 || exp_valid[cur] || cursor + len > 128 ||
          cursor + koff + (wide != 0 ? 2 : 1) > 128) begin
        exp_err = 1; exp_lat = 2 * n; done = 1;
      end else begin
        exp_parsed[cur] = 32'(cursor);
        exp_valid[cur]  = 1'b1;
        a = cursor + koff;
        key = (wide != 0) ? int'(pkt[a]) * 256 + int'(pkt[a+1]) : int'(pkt[a]);
        cursor += len;
        found = 0; nxt = 0;
        for (int t = 0; t < 4; t++) begin
          if (!found && trans[cur][t][23] && int'(trans[cur][t][15:0]) == key) begin
            found = 1; nxt = int'(trans[cur][t][19:16]);
          end
        end
        if (found) cur = nxt;
        else begin exp_lat = 2 * n + 1; done = 1; end
      end
    end
  endtask

  task automatic clear_cfg();
    for (int h = 0; h < 16; h++) begin
      cfg[h] = '0;
      for (int t = 0; t < 4; t++) trans[h][t] = '0;
    end
  endtask

  function automatic logic [15:0] mk_cfg(int len, int koff, bit wide);
    return {8'(len), 6'(koff), wide, 1'b0};
  endfunction

  function automatic logic [23:0] mk_tr(int nxt, int val);
    return {1'b1, 3'b000, 4'(nxt), 16'(val)};
  endfunction

  task automatic drive_cfg_pins();
    for (int h = 0; h < 16; h++) begin
      mod_hdr_cfg_i[h] = cfg[h];
      for (int t = 0; t < 4; t++) mod_trans_i[h*4+t] = trans[h][t];
    end
  endtask

  task automatic load_cfg();
    @(negedge clk);
    drive_cfg_pins();
    mod_start_i = 1'b1;
    @(negedge clk);
    mod_start_i = 1'b0;
  endtask

  task automatic drive_pkt();
    for (int i = 0; i < 128; i++) pkt_hdr_i[i] = pkt[i];
  endtask

  task automatic set_eth_cfg();
    clear_cfg();
    cfg[0]      = mk_cfg(14, 12, 1'b1);
    trans[0][0] = mk_tr(1, 16'h0800);
    cfg[1]      = mk_cfg(20, 9, 1'b0);
    trans[1][0] = mk_tr(2, 16'h0011);
    cfg[2]      = mk_cfg(8, 0, 1'b0);
  endtask

  task automatic set_eth_pkt(logic [15:0] etype);
    for (int i = 0; i < 128; i++) pkt[i] = 8'($urandom);
    pkt[12] = etype[15:8];
    pkt[13] = etype[7:0];
    pkt[23] = 8'h11;
  endtask

  // Start one parse, measure latency and compare every output with the model.
  task automatic run_and_check(string name);
    int cnt, bad;
    model();
    @(negedge clk);
    drive_pkt();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cnt = 0;
    while (cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
      if (ready_o) break;
    end
    last_lat = cnt;
    n_checks++;
    if (cnt !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges, want %0d", name, cnt, exp_lat);
    end
    n_checks++;
    if (err_o !== exp_err) begin
      n_fail++;
      $display("FAIL %s err_o: got %b want %b", name, err_o, exp_err);
    end
    n_checks++;
    if (hdr_valid_o !== exp_valid) begin
      n_fail++;
      $display("FAIL %s hdr_valid_o: got %h want %h", name, hdr_valid_o, exp_valid);
    end
    n_checks++;
    if (parsed_hdrs_o !== exp_parsed) begin
      n_fail++;
      $display("FAIL %s parsed_hdrs_o: got %h want %h", name, parsed_hdrs_o, exp_parsed);
    end
    bad = -1;
    for (int i = 127; i >= 0; i--) if (pkt_hdr_o[i] !== pkt[i]) bad = i;
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s pkt_hdr_o byte %0d: got %h want %h", name, bad, pkt_hdr_o[bad], pkt[bad]);
    end
    @(posedge clk); #1;
    n_checks++;
    if (ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ready_o pulse width: got %b want 0", name, ready_o);
    end
  endtask

  task automatic check_outputs_zero(string name);
    n_checks++;
    if (ready_o !== 1'b0 || err_o !== 1'b0 || hdr_valid_o !== '0 ||
        parsed_hdrs_o !== '0 || pkt_hdr_o !== '0) begin
      n_fail++;
      $display("FAIL %s outputs: got ready=%b err=%b valid=%h want all zero",
               name, ready_o, err_o, hdr_valid_o);
    end
  endtask

  task automatic test_reset();
    check_outputs_zero("reset");
    clear_cfg();
    for (int i = 0; i < 128; i++) pkt[i] = 8'($urandom);
    run_and_check("reset_empty_tables");
  endtask

  task automatic test_eth();
    set_eth_cfg();
    load_cfg();
    set_eth_pkt(16'h0800);
    run_and_check("eth_ipv4_udp");
    n_checks++;
    if (last_lat !== 7 || hdr_valid_o !== 16'h0007 || parsed_hdrs_o[1] !== 32'd14 ||
        parsed_hdrs_o[2] !== 32'd34) begin
      n_fail++;
      $display("FAIL eth_fixed: got lat=%0d valid=%h off1=%0d off2=%0d want 7/0007/14/34",
               last_lat, hdr_valid_o, parsed_hdrs_o[1], parsed_hdrs_o[2]);
    end
  endtask

  task automatic test_no_match();
    set_eth_pkt(16'h86DD);
    run_and_check("eth_no_match");
    n_checks++;
    if (last_lat !== 3 || hdr_valid_o !== 16'h0001 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL no_match_fixed: got lat=%0d valid=%h err=%b want 3/0001/0",
               last_lat, hdr_valid_o, err_o);
    end
  endtask

  task automatic test_loop_and_unconfigured();
    set_eth_cfg();
    trans[1][0] = mk_tr(0, 16'h0011);
    load_cfg();
    set_eth_pkt(16'h0800);
    run_and_check("loop");
    n_checks++;
    if (last_lat !== 6 || hdr_valid_o !== 16'h0003 || err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL loop_fixed: got lat=%0d valid=%h err=%b want 6/0003/1",
               last_lat, hdr_valid_o, err_o);
    end
    set_eth_cfg();
    cfg[2] = '0;
    load_cfg();
    run_and_check("unconfigured");
    n_checks++;
    if (hdr_valid_o !== 16'h0003 || err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL unconfigured_fixed: got valid=%h err=%b want 0003/1", hdr_valid_o, err_o);
    end
  endtask

  task automatic test_bounds();
    clear_cfg();
    cfg[0]      = mk_cfg(120, 12, 1'b1);
    trans[0][0] = mk_tr(1, 16'h0800);
    cfg[1]      = mk_cfg(20, 0, 1'b0);
    load_cfg();
    set_eth_pkt(16'h0800);
    run_and_check("bounds");
    n_checks++;
    if (err_o !== 1'b1 || parsed_hdrs_o[1] !== 32'd0 || hdr_valid_o !== 16'h0001) begin
      n_fail++;
      $display("FAIL bounds_fixed: got err=%b off1=%0d valid=%h want 1/0/0001",
               err_o, parsed_hdrs_o[1], hdr_valid_o);
    end
  endtask

  task automatic test_arbitration();
    int seen;
    logic [15:0] prev_valid;
    prev_valid = hdr_valid_o;
    // Priority config: entries 1 and 2 both match 0x0800.
    clear_cfg();
    cfg[0]      = mk_cfg(14, 12, 1'b1);
    trans[0][0] = {1'b0, 3'b000, 4'd3, 16'h0800};
    trans[0][1] = mk_tr(1, 16'h0800);
    trans[0][2] = mk_tr(2, 16'h0800);
    cfg[1]      = mk_cfg(20, 0, 1'b0);
    cfg[2]      = mk_cfg(20, 0, 1'b0);
    cfg[3]      = mk_cfg(20, 0, 1'b0);
    set_eth_pkt(16'h0800);
    @(negedge clk);
    drive_cfg_pins();
    drive_pkt();
    mod_start_i = 1'b1;
    start_i     = 1'b1;
    @(negedge clk);
    mod_start_i = 1'b0;
    start_i     = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ready_o) seen++;
    end
    n_checks++;
    if (seen !== 0 || hdr_valid_o !== prev_valid) begin
      n_fail++;
      $display("FAIL start_with_mod: got %0d ready pulses valid=%h want 0 pulses valid=%h",
               seen, hdr_valid_o, prev_valid);
    end
    run_and_check("priority");
    n_checks++;
    if (hdr_valid_o !== 16'h0003) begin
      n_fail++;
      $display("FAIL priority_fixed: got valid=%h want 0003", hdr_valid_o);
    end
    // start_i pulsed in the middle of a parse must not queue a second one.
    set_eth_cfg();
    load_cfg();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (ready_o) seen++;
    end
    n_checks++;
    if (seen !== 1) begin
      n_fail++;
      $display("FAIL mid_parse_start: got %0d ready pulses want 1", seen);
    end
  endtask

  task automatic test_async_reset();
    set_eth_cfg();
    load_cfg();
    set_eth_pkt(16'h0800);
    @(negedge clk);
    drive_pkt();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);   // EXTRACT -> LOOKUP
    #2 rst = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    clear_cfg();
    run_and_check("after_reset");
    n_checks++;
    if (err_o !== 1'b1 || last_lat !== 2) begin
      n_fail++;
      $display("FAIL after_reset_fixed: got err=%b lat=%0d want 1/2", err_o, last_lat);
    end
  endtask

  task automatic test_random();
    int vals [4];
    vals[0] = 16'h0000; vals[1] = 16'h0001; vals[2] = 16'h0100; vals[3] = 16'h0101;
    for (int it = 0; it < 12; it++) begin
      clear_cfg();
      for (int h = 0; h < 16; h++) begin
        cfg[h] = mk_cfg(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40)),
                        int'($urandom_range(0, 20)), 1'($urandom));
        for (int t = 0; t < 4; t++) begin
          trans[h][t] = mk_tr(int'($urandom_range(0, 15)), vals[$urandom_range(0, 3)]);
          trans[h][t][23] = 1'($urandom_range(0, 3) != 0);
        end
      end
      for (int i = 0; i < 128; i++) pkt[i] = 8'($urandom_range(0, 1));
      load_cfg();
      run_and_check($sformatf("random_%0d", it));
    end
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    mod_start_i = 1'b0;
    pkt_hdr_i = '0;
    mod_hdr_cfg_i = '0;
    mod_trans_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_eth();
    test_no_match();
    test_loop_and_unconfigured();
    test_bounds();
    test_arbitration();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
